instr_sequencer: RTL and testbench
==================================

# instr_sequencer

- Multi-cycle fetch/execute controller for the 16-bit mycpu core.
- Fetches each instruction from instruction memory through a req/ack handshake, latches it, and evaluates the jump condition against the ALU flags.
- Sequences the A/D register loads and the data-memory write, then drives the program counter's `load`/`inc` strobes.
- Sits between instruction memory, the register file/ALU, and the PC.

## Interface
Parameters:
- `N`, 16, instruction/data width

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `run`  in  1  level; 1 = keep executing, 0 = park in IDLE after the current instruction
- `imem_req`  out  1  instruction fetch request
- `imem_ack`  in  1  fetch complete; `imem_rdata` valid this cycle
- `imem_rdata`  in  N  fetched instruction
- `ir`  out  N  latched instruction (drives ALU control and A-constant)
- `alu_zero`, `alu_neg`  in  1 each  combinational ALU flags for the current `ir`
- `m_we`  out  1  data-memory write request (address = A, data = ALU out)
- `dmem_ack`  in  1  write accepted
- `a_load`, `d_load`  out  1 each  register write strobes
- `pc_load`, `pc_inc`  out  1 each  PC strobes
- `busy`  out  1  state != IDLE

## Operation
- **Instruction decode**
  - `ir[15]` = 0: A-instruction.
  - `ir[15]` = 1: C-instruction, with dest `ir[5]` = A, `ir[4]` = D, `ir[3]` = M, and jump field `ir[2:0]`.
- **States**
  - **IDLE**
    - All strobes 0.
    - `run` = 1 → FETCH.
  - **FETCH**
    - `imem_req` = 1, held until `imem_ack`.
    - On `imem_ack`: `ir` ← `imem_rdata`, → DECODE.
  - **DECODE**
    - Latches `taken` = C & (`j`==7 | `j[2]`&neg | `j[1]`&zero | `j[0]`&!zero&!neg).
    - → MEMWR if C & `ir[3]`, else → EXEC.
  - **MEMWR**
    - `m_we` = 1, held until `dmem_ack`; the ack cycle → EXEC.
  - **EXEC** (exactly one cycle)
    - `a_load` = !C | `ir[5]`; `d_load` = C & `ir[4]`.
    - `pc_load` = `taken`, `pc_inc` = !`taken`.
    - → FETCH if `run`, else → IDLE.
- **Invariants**
  - `pc_load` and `pc_inc` are mutually exclusive and pulse exactly once per instruction.
  - `imem_req` and `m_we` are never high together.
  - `ir` holds its value outside FETCH-ack.
- **Jump target**
  - PC and A sample at the same EXEC edge, so a jump uses the pre-update A.
- **`run` sampling**
  - `run` is sampled only in IDLE and at EXEC exit; a mid-instruction drop never aborts.
- **Reset**
  - Assertion at any time → IDLE immediately (asynchronous).
  - `ir` = 0, `taken` = 0, all outputs 0; an outstanding req/we is dropped.
  - Memories must tolerate an abandoned request.

## Timing
- **Latency**
  - Zero-wait `imem_ack` (same cycle as req): 3 cycles per instruction (FETCH, DECODE, EXEC).
  - Plus 1 cycle with an M write and zero-wait `dmem_ack`.
  - Plus 1 cycle per wait-state on either ack.
- **Handshakes**
  - An ack while the corresponding req is low is ignored.
- **ALU flags**
  - `alu_zero`/`alu_neg` are sampled only at the DECODE clock edge.
- **Back-to-back instructions**
  - `imem_req` rises in the cycle after EXEC; there is no idle gap.

## Configuration
- **`MYCPU_STEP_EN` defined**
  - Adds input `step` (1 bit).
  - In IDLE with `run` = 0, a `step` pulse executes exactly one instruction, then returns to IDLE.
  - `step` is ignored outside IDLE.
- **`MYCPU_STEP_EN` undefined**
  - Port absent; behaviour as above.

## Structure
- **Package `mycpu_pkg`**
  - State enum: IDLE, FETCH, DECODE, MEMWR, EXEC.
  - Bit-position constants: C bit 15, DEST_A 5, DEST_D 4, DEST_M 3, JUMP field [2:0].
  - Jump codes: NULL, JGT, JEQ, JGE, JLT, JNE, JLE, JMP.
- **Sub-module `jump_eval`**
  - Combinational (`jump[2:0]`, `zero`, `neg`) → `taken`.
  - Used in DECODE.

## Test plan
- **Reset mid-FETCH:** `rst` = 0 with `imem_req` high → all outputs 0 the same cycle; `busy` = 0; after release with `run` = 1, `imem_req` = 1 on the next cycle.
- **A-instruction:** `imem_rdata` = 0x0005, zero-wait ack → `imem_req` cycle 1, DECODE cycle 2, EXEC cycle 3 with `a_load` = 1, `pc_inc` = 1, `d_load` = 0; `ir` = 0x0005.
- **C-instruction JGT:** `ir` = 0xE301, flags zero = 0, neg = 0 → `pc_load` = 1, `pc_inc` = 0, `d_load` = 0; repeat with neg = 1 → `pc_inc` = 1.
- **M write with waits:** `ir` = 0xE308, `dmem_ack` after 3 cycles → `m_we` high for 3 cycles; EXEC follows the ack; 6 cycles total.
- **`run` dropped mid-instruction:** `run` = 0 during DECODE → EXEC completes with one PC strobe, then IDLE; no further `imem_req`.
- **Single step (`MYCPU_STEP_EN`):** `run` = 0 → exactly one `pc_inc` pulse per `step` pulse; `step` during FETCH is ignored.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared definitions for the mycpu sequencer: FSM states, instruction bit positions, jump codes.
package mycpu_pkg;

  localparam int unsigned C_BIT   = 15;
  localparam int unsigned DEST_A  = 5;
  localparam int unsigned DEST_D  = 4;
  localparam int unsigned DEST_M  = 3;
  localparam int unsigned JUMP_HI = 2;
  localparam int unsigned JUMP_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEMWR,
    ST_EXEC
  } state_e;

  typedef enum logic [2:0] {
    J_NULL,
    J_JGT,
    J_JEQ,
    J_JGE,
    J_JLT,
    J_JNE,
    J_JLE,
    J_JMP
  } jump_e;

endpackage

// File: rtl/jump_eval.sv
// Combinational jump-condition evaluation from the 3-bit jump field and ALU flags.
module jump_eval
  import mycpu_pkg::*;
(
  input  logic [2:0] jump_i,
  input  logic       zero_i,
  input  logic       neg_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = (jump_e'(jump_i) == J_JMP)
            | (jump_i[2] & neg_i)
            | (jump_i[1] & zero_i)
            | (jump_i[0] & ~zero_i & ~neg_i);
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the mycpu core.
// Optional single-step input enabled by defining MYCPU_STEP_EN.
module instr_sequencer
  import mycpu_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
`ifdef MYCPU_STEP_EN
  input  logic         step,
`endif
  output logic         imem_req,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] ir,
  input  logic         alu_zero,
  input  logic         alu_neg,
  output logic         m_we,
  input  logic         dmem_ack,
  output logic         a_load,
  output logic         d_load,
  output logic         pc_load,
  output logic         pc_inc,
  output logic         busy
);

  state_e         state_q, state_d;
  logic [N-1:0]   ir_q, ir_d;
  logic           taken_q, taken_d;
  logic           is_c;
  logic           jump_taken;
  logic           start;

  assign is_c = ir_q[C_BIT];
  assign ir   = ir_q;

`ifdef MYCPU_STEP_EN
  assign start = run | step;
`else
  assign start = run;
`endif

  jump_eval u_jump_eval (
    .jump_i  (ir_q[JUMP_HI:JUMP_LO]),
    .zero_i  (alu_zero),
    .neg_i   (alu_neg),
    .taken_o (jump_taken)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    taken_d  = taken_q;
    imem_req = 1'b0;
    m_we     = 1'b0;
    a_load   = 1'b0;
    d_load   = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    busy     = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Flags reflect the freshly latched ir, so they are sampled here only.
        taken_d = is_c & jump_taken;
        state_d = (is_c && ir_q[DEST_M]) ? ST_MEMWR : ST_EXEC;
      end
      ST_MEMWR: begin
        m_we = 1'b1;
        if (dmem_ack) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        a_load  = ~is_c | ir_q[DEST_A];
        d_load  = is_c & ir_q[DEST_D];
        pc_load = taken_q;
        pc_inc  = ~taken_q;
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected EXEC results, a monitor pops on each PC strobe.
module tb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
`ifdef MYCPU_STEP_EN
  logic        step;
`endif
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ir;
  logic        alu_zero;
  logic        alu_neg;
  logic        m_we;
  logic        dmem_ack;
  logic        a_load;
  logic        d_load;
  logic        pc_load;
  logic        pc_inc;
  logic        busy;

  instr_sequencer #(.N(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
`ifdef MYCPU_STEP_EN
    .step       (step),
`endif
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .m_we       (m_we),
    .dmem_ack   (dmem_ack),
    .a_load     (a_load),
    .d_load     (d_load),
    .pc_load    (pc_load),
    .pc_inc     (pc_inc),
    .busy       (busy)
  );

  typedef struct {
    logic [15:0] ir;
    logic        a;
    logic        d;
    logic        pl;
    int unsigned cyc;
    int unsigned mwe;
  } exp_t;

  exp_t sb[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: measures instruction length from the rising fetch request and checks on each PC strobe.
  logic        mon_prev_req = 1'b0;
  int unsigned mon_cyc = 0;
  int unsigned mon_mwe = 0;
  exp_t        mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (imem_req && !mon_prev_req) begin
          mon_cyc = 0;
          mon_mwe = 0;
        end
        if (busy) mon_cyc++;
        if (m_we) mon_mwe++;
        if (pc_load || pc_inc) begin
          if (sb.size() == 0) begin
            check("unexpected_exec", 32'({pc_load, pc_inc}), 32'd0);
          end else begin
            mon_e = sb.pop_front();
            check("ir",        32'(ir),                 32'(mon_e.ir));
            check("a_load",    32'(a_load),             32'(mon_e.a));
            check("d_load",    32'(d_load),             32'(mon_e.d));
            check("pc_strobe", 32'({pc_load, pc_inc}),  32'({mon_e.pl, ~mon_e.pl}));
            check("exec_quiet",32'({imem_req, m_we}),   32'd0);
            check("cycles",    mon_cyc,                 mon_e.cyc);
            check("m_we_cyc",  mon_mwe,                 mon_e.mwe);
          end
        end
        mon_prev_req = imem_req;
      end else begin
        mon_prev_req = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Serve one instruction: iw fetch wait-states, mc cycles of m_we (0 = no M write).
  task automatic do_instr(input logic [15:0] instr, input logic z, input logic n,
                          input int unsigned iw, input int unsigned mc,
                          input logic ea, input logic ed, input logic epl, input logic drop);
    exp_t e;
    int unsigned t;
    e.ir = instr; e.a = ea; e.d = ed; e.pl = epl;
    e.cyc = 3 + iw + mc; e.mwe = mc;
    sb.push_back(e);
    alu_zero = z;
    alu_neg  = n;
    t = 0;
    while (!imem_req && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!imem_req) begin
      check("fetch_req", 32'(imem_req), 32'd1);
      return;
    end
    repeat (iw) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 16'hBEEF;
    if (drop) run = 1'b0;
    if (mc > 0) begin
      t = 0;
      while (!m_we && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (!m_we) begin
        check("memwr_req", 32'(m_we), 32'd1);
        return;
      end
      repeat (mc - 1) @(negedge clk);
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic expect_idle(input string name);
    logic seen;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | imem_req | busy;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    rst = 1'b0; run = 1'b0;
`ifdef MYCPU_STEP_EN
    step = 1'b0;
`endif
    imem_ack = 1'b0; imem_rdata = '0; alu_zero = 1'b0; alu_neg = 1'b0; dmem_ack = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_outs", 32'({imem_req, m_we, a_load, d_load, pc_load, pc_inc, busy}), 32'd0);
    check("reset_ir", 32'(ir), 32'd0);
    rst = 1'b1;

    // Acks with no request pending must be ignored.
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 16'hFFFF; dmem_ack = 1'b1;
    repeat (2) @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    check("stray_ack_ir", 32'(ir), 32'd0);
    check("stray_ack_busy", 32'(busy), 32'd0);

    // Reset while a fetch request is outstanding.
    run = 1'b1;
    @(negedge clk);
    check("fetch_start", 32'(imem_req), 32'd1);
    #2 rst = 1'b0;
    #1 check("midfetch_reset", 32'({imem_req, m_we, a_load, d_load, pc_load, pc_inc, busy}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("req_after_release", 32'(imem_req), 32'd1);

    do_instr(16'h0005, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_instr(16'hE301, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_instr(16'hE301, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(16'hE308, 1'b0, 1'b0, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(16'hE310, 1'b1, 1'b0, 2, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_instr(16'hE327, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    do_instr(16'hE302, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_instr(16'hE305, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_instr(16'hE33C, 1'b0, 1'b1, 1, 1, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_idle("idle_after_drop");

    run = 1'b1;
    do_instr(16'h7FFF, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_idle("idle_after_drop2");

`ifdef MYCPU_STEP_EN
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    do_instr(16'h0001, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_idle("idle_after_step");

    // Step held through the first FETCH cycle must not start a second instruction.
    step = 1'b1;
    fork
      begin
        @(negedge clk);
        @(negedge clk);
        step = 1'b0;
      end
      do_instr(16'h0002, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    join
    expect_idle("idle_after_step_in_fetch");
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
